// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch queue: FSM states, queue entry layout, reset PC.
// No logic; no latency or backpressure of its own.
package prefetch_pkg;

    localparam int PF_WIDTH = 32;
    localparam logic [PF_WIDTH-1:0] PF_RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FULL
    } pf_state_t;

    typedef struct packed {
        logic [PF_WIDTH-1:0] pc;
        logic [PF_WIDTH-1:0] instr;
    } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo_mem.sv
// Prefetch queue storage: DEPTH x DW register array.
// Write lands on the rising edge; read at i_rd_ptr is combinational.
// No flow control here; the owner gates i_wr_en. Storage is not reset.
module prefetch_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_ptr,
    input  logic [DW-1:0] i_wr_dat,
    input  logic [AW-1:0] i_rd_ptr,
    output logic [DW-1:0] o_rd_dat
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_ptr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Prefetch queue between compressed imem and the decompressor: queues {pc, word} pairs.
// One cycle fetch->dequeue latency, no bypass; redirect flushes and restarts at redirect_pc.
// Stops fetching when full unless the head pops in the same cycle; fetch_en=0 freezes fetch_pc.
module instr_prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int               WIDTH = PF_WIDTH,
    parameter logic [WIDTH-1:0] PCADD = WIDTH'(4),
    parameter int               DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic [WIDTH-1:0]         imem_addr,
    input  logic [WIDTH-1:0]         imem_rdata,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [WIDTH-1:0]         deq_pc,
    output logic [WIDTH-1:0]         deq_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0]   r_fetch_pc;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    pf_state_t          r_state;
    pf_state_t          w_state_nxt;

    logic               w_pop;
    logic               w_push;
    logic [CW-1:0]      w_count_nxt;
    logic [2*WIDTH-1:0] w_wr_dat;
    logic [2*WIDTH-1:0] w_rd_dat;

    assign deq_valid = (r_count != '0);
    assign w_pop     = deq_valid & deq_ready;
    // A full queue may still accept a word if the head leaves on the same edge.
    assign w_push    = fetch_en & ~redirect & ((r_count != FULL_CNT) | w_pop);
    assign w_wr_dat  = {r_fetch_pc, imem_rdata};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= WIDTH'(PF_RESET_PC);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_fetch_pc <= r_fetch_pc + PCADD;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = fetch_en ? FETCH : IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (fetch_en) w_state_nxt = FETCH;
                end
                FETCH: begin
                    if (!fetch_en)                    w_state_nxt = IDLE;
                    else if (w_count_nxt == FULL_CNT) w_state_nxt = FULL;
                end
                FULL: begin
                    if (!fetch_en)  w_state_nxt = IDLE;
                    else if (w_pop) w_state_nxt = FETCH;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    prefetch_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (2*WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .i_wr_en  (w_push),
        .i_wr_ptr (r_wr_ptr),
        .i_wr_dat (w_wr_dat),
        .i_rd_ptr (r_rd_ptr),
        .o_rd_dat (w_rd_dat)
    );

    // Storage is never reset, so the head is masked to zero whenever the queue is empty.
    assign deq_pc    = deq_valid ? w_rd_dat[2*WIDTH-1:WIDTH] : '0;
    assign deq_instr = deq_valid ? w_rd_dat[WIDTH-1:0]       : '0;
    assign imem_addr = r_fetch_pc;
    assign count     = r_count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus random traffic against a queue model.
module tb_instr_prefetch_queue;
    import prefetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mq[$];
    logic [31:0] mpc;

    instr_prefetch_queue #(.WIDTH(32), .PCADD(32'h4), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_pc      (deq_pc),
        .deq_instr   (deq_instr),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return 32'hA000_0000 + (addr >> 2);
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    function automatic logic        exp_valid();
        return mq.size() != 0;
    endfunction
    function automatic logic [31:0] exp_pc();
        logic [63:0] e;
        if (mq.size() == 0) return 32'h0;
        e = mq[0];
        return e[63:32];
    endfunction
    function automatic logic [31:0] exp_instr();
        logic [63:0] e;
        if (mq.size() == 0) return 32'h0;
        e = mq[0];
        return e[31:0];
    endfunction

    // One clock: apply the queue rules to the model at the edge, return at the falling edge.
    task automatic cycle();
        bit pop, push;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            mpc = 32'h0;
        end else if (redirect) begin
            mq.delete();
            mpc = redirect_pc;
        end else begin
            pop  = (mq.size() > 0) && deq_ready;
            push = fetch_en && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({mpc, imem_word(mpc)});
                mpc = mpc + 32'h4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        repeat (3) cycle();
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        n_tests++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", deq_valid); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_tests++; if (deq_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", deq_instr); end
        n_tests++; if (deq_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", deq_pc); end
    endtask

    task automatic test_fill();
        reset = 1'b1;
        fetch_en = 1'b1; deq_ready = 1'b0;
        repeat (4) cycle();
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", count); end
        n_tests++; if (dut.r_state !== FULL) begin n_fail++; $display("FAIL fill_state got=%0d exp=%0d", dut.r_state, FULL); end
        n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL fill_addr got=%h exp=10", imem_addr); end
        n_tests++; if (deq_pc !== 32'h0) begin n_fail++; $display("FAIL fill_head_pc got=%h exp=0", deq_pc); end
        n_tests++; if (deq_instr !== 32'hA000_0000) begin n_fail++; $display("FAIL fill_head_instr got=%h exp=a0000000", deq_instr); end
        repeat (2) cycle();
        n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL fill_hold_addr got=%h exp=10", imem_addr); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_hold_count got=%0d exp=4", count); end
    endtask

    task automatic test_full_pop();
        deq_ready = 1'b1;
        cycle();
        deq_ready = 1'b0;
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count got=%0d exp=4", count); end
        n_tests++; if (deq_pc !== 32'h4) begin n_fail++; $display("FAIL fullpop_head got=%h exp=4", deq_pc); end
        n_tests++; if (deq_instr !== 32'hA000_0001) begin n_fail++; $display("FAIL fullpop_instr got=%h exp=a0000001", deq_instr); end
        n_tests++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL fullpop_addr got=%h exp=14", imem_addr); end
        n_tests++; if (mq[DEPTH-1][63:32] !== 32'h10) begin n_fail++; $display("FAIL fullpop_model_tail got=%h exp=10", mq[DEPTH-1][63:32]); end
    endtask

    task automatic test_stream();
        redirect = 1'b1; redirect_pc = 32'h0; deq_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        cycle();
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (deq_valid !== 1'b1 || deq_pc !== 32'(4*k)) begin
                n_fail++; $display("FAIL stream_pc[%0d] got=%b/%h exp=1/%h", k, deq_valid, deq_pc, 32'(4*k));
            end
            n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count); end
            cycle();
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h100; deq_ready = 1'b0;
        cycle();
        redirect = 1'b0;
        repeat (3) cycle();
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
        redirect = 1'b1; redirect_pc = 32'h40; deq_ready = 1'b1;
        cycle();
        redirect = 1'b0; deq_ready = 1'b0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_count got=%0d exp=0", count); end
        n_tests++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got=%b exp=0", deq_valid); end
        n_tests++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_addr got=%h exp=40", imem_addr); end
        n_tests++; if (deq_pc !== 32'h0) begin n_fail++; $display("FAIL redir_pc_clean got=%h exp=0", deq_pc); end
        cycle();
        n_tests++; if (deq_pc !== 32'h40) begin n_fail++; $display("FAIL redir_first_pc got=%h exp=40", deq_pc); end
        n_tests++; if (deq_instr !== 32'hA000_0010) begin n_fail++; $display("FAIL redir_first_instr got=%h exp=a0000010", deq_instr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            fetch_en    = ($urandom_range(0, 3) != 0);
            deq_ready   = $urandom_range(0, 1) == 1;
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            cycle();
            n_tests++;
            if (deq_valid !== exp_valid() || deq_pc !== exp_pc() || deq_instr !== exp_instr() ||
                count !== 3'(mq.size()) || imem_addr !== mpc) begin
                n_fail++;
                $display("FAIL random[%0d] got v=%b pc=%h in=%h cnt=%0d addr=%h exp v=%b pc=%h in=%h cnt=%0d addr=%h",
                         i, deq_valid, deq_pc, deq_instr, count, imem_addr,
                         exp_valid(), exp_pc(), exp_instr(), mq.size(), mpc);
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_wrap_async_reset();
        redirect = 1'b1; redirect_pc = 32'h0; fetch_en = 1'b1; deq_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_tests++;
            if (deq_valid !== 1'b1 || deq_pc !== exp_pc() || deq_instr !== imem_word(deq_pc)) begin
                n_fail++;
                $display("FAIL wrap[%0d] got v=%b pc=%h in=%h exp v=1 pc=%h in=%h",
                         i, deq_valid, deq_pc, deq_instr, exp_pc(), imem_word(exp_pc()));
            end
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        mq.delete();
        mpc = 32'h0;
        n_tests++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", deq_valid); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_count got=%0d exp=0", count); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL async_addr got=%h exp=0", imem_addr); end
        fetch_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_tests++; if (deq_valid !== 1'b0 || deq_pc !== 32'h0) begin
                n_fail++; $display("FAIL post_reset_valid[%0d] got v=%b pc=%h exp v=0 pc=0", i, deq_valid, deq_pc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        mpc = 32'h0;
        test_reset();
        test_fill();
        test_full_pop();
        test_stream();
        test_redirect();
        test_random();
        test_wrap_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
